fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 19 +
 rtl/fetch_queue.sv | 90 +++++++++
 tb/tb_fetch_queue.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared pipeline types for the fetch queue.
// Provides word_t, fetch_data_t and the FETCH_QUEUE_DEPTH constant.
package fetch_queue_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t raw_instr;
    } instr_t;

    typedef struct packed {
        logic   valid;
        instr_t instr;
    } fetch_data_t;

    localparam int FETCH_QUEUE_DEPTH = 4;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: circular buffer between fetch output and decode register.
// Ports: clk, reset (sync, active-high), flush, enq_valid, dataF in;
//        full, dataD, count out; deq_ready in (decode not stalled).
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       enq_valid,
    input  fetch_data_t                dataF,
    output logic                       full,
    output fetch_data_t                dataD,
    input  logic                       deq_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_data_t     mem_q [DEPTH];
    fetch_data_t     mem_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic empty;
    logic enq;
    logic deq;

    // Status comes from the registered count only, so deq_ready never
    // reaches full combinationally.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

    assign enq = enq_valid && dataF.valid && !full && !flush;
    assign deq = !empty && deq_ready && !flush;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                mem_d[tail_q] = dataF;
                tail_d        = tail_q + PW'(1);
            end
            if (deq) begin
                head_d = head_q + PW'(1);
            end
            unique case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Entries are never cleared; the output is gated on empty instead.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        dataD = '0;
        if (!empty) begin
            dataD       = mem_q[head_q];
            dataD.valid = 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue.
// Linear stimulus; immediate assertions at every check point.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        enq_valid;
    fetch_data_t dataF;
    logic        full;
    fetch_data_t dataD;
    logic        deq_ready;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    fetch_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .enq_valid (enq_valid),
        .dataF     (dataF),
        .full      (full),
        .dataD     (dataD),
        .deq_ready (deq_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [95:0] obs,
                       input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_enq(input logic [31:0] pc,
                           input logic [31:0] raw);
        enq_valid          = 1'b1;
        dataF.valid        = 1'b1;
        dataF.instr.pc     = pc;
        dataF.instr.raw_instr = raw;
    endtask

    task automatic clr_enq();
        enq_valid = 1'b0;
        dataF     = '0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        deq_ready = 1'b0;
        clr_enq();
        step();
        step();
        reset = 1'b0;
        chk("rst_count", 96'(count), 96'd0);
        chk("rst_full", 96'(full), 96'd0);
        chk("rst_dataD", 96'(dataD), 96'd0);

        // single enqueue, one-cycle latency
        set_enq(32'h8000_0000, 32'h0000_0013);
        step();
        clr_enq();
        chk("lat_valid", 96'(dataD.valid), 96'd1);
        chk("lat_pc", 96'(dataD.instr.pc), 96'h8000_0000);
        chk("lat_raw", 96'(dataD.instr.raw_instr), 96'h13);
        chk("lat_count", 96'(count), 96'd1);

        // fill to full
        for (int i = 1; i < 4; i++) begin
            set_enq(32'h8000_0000 + 32'(4 * i), 32'(i));
            step();
        end
        chk("fill_count", 96'(count), 96'd4);
        chk("fill_full", 96'(full), 96'd1);
        chk("stall_pc", 96'(dataD.instr.pc), 96'h8000_0000);
        set_enq(32'h8000_0010, 32'h55);
        step();
        clr_enq();
        chk("rej_count", 96'(count), 96'd4);
        chk("rej_pc", 96'(dataD.instr.pc), 96'h8000_0000);

        // drain in order
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", 96'(dataD.instr.pc),
                96'(32'h8000_0000 + 32'(4 * i)));
            step();
            chk("drain_cnt", 96'(count), 96'(3 - i));
            chk("drain_full", 96'(full), 96'd0);
        end
        chk("drain_dataD", 96'(dataD), 96'd0);

        // enq_valid with invalid data is ignored
        enq_valid   = 1'b1;
        dataF.valid = 1'b0;
        dataF.instr.pc = 32'h1234;
        step();
        clr_enq();
        chk("inv_count", 96'(count), 96'd0);
        chk("inv_valid", 96'(dataD.valid), 96'd0);

        // steady state at count=2 with wrap
        deq_ready = 1'b0;
        set_enq(32'h0000_00A0, 32'h1);
        step();
        set_enq(32'h0000_00A4, 32'h2);
        step();
        chk("ss_pre_cnt", 96'(count), 96'd2);
        deq_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_enq(32'h0000_00A8 + 32'(4 * i), 32'h3);
            chk("ss_pc", 96'(dataD.instr.pc),
                96'(32'h0000_00A0 + 32'(4 * i)));
            step();
            chk("ss_cnt", 96'(count), 96'd2);
        end
        chk("ss_head", 96'(dataD.instr.pc), 96'h0C8);

        // count=3 then flush with enq and deq
        deq_ready = 1'b0;
        set_enq(32'h0000_00D0, 32'h4);
        step();
        chk("pre_fl_cnt", 96'(count), 96'd3);
        flush     = 1'b1;
        deq_ready = 1'b1;
        set_enq(32'hDEAD_0000, 32'hBAD);
        step();
        flush     = 1'b0;
        deq_ready = 1'b0;
        clr_enq();
        chk("fl_count", 96'(count), 96'd0);
        chk("fl_dataD", 96'(dataD), 96'd0);
        step();
        chk("fl_drop", 96'(dataD.valid), 96'd0);

        // full: simultaneous deq+enq, enqueue rejected
        for (int i = 0; i < 4; i++) begin
            set_enq(32'h0000_0100 + 32'(4 * i), 32'h7);
            step();
        end
        chk("f2_full", 96'(full), 96'd1);
        chk("f2_head", 96'(dataD.instr.pc), 96'h100);
        set_enq(32'h0000_0110, 32'h8);
        deq_ready = 1'b1;
        step();
        clr_enq();
        chk("f2_cnt", 96'(count), 96'd3);
        chk("f2_pc", 96'(dataD.instr.pc), 96'h104);
        step();
        step();
        chk("f2_last", 96'(dataD.instr.pc), 96'h10C);
        step();
        chk("f2_empty", 96'(dataD.valid), 96'd0);
        chk("f2_cnt0", 96'(count), 96'd0);

        // count=3 then reset overrides everything
        deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_enq(32'h0000_0200 + 32'(4 * i), 32'h9);
            step();
        end
        chk("pre_rst_cnt", 96'(count), 96'd3);
        reset     = 1'b1;
        flush     = 1'b1;
        deq_ready = 1'b1;
        set_enq(32'h0000_0300, 32'hA);
        step();
        reset     = 1'b0;
        flush     = 1'b0;
        deq_ready = 1'b0;
        clr_enq();
        chk("mr_count", 96'(count), 96'd0);
        chk("mr_full", 96'(full), 96'd0);
        chk("mr_dataD", 96'(dataD), 96'd0);

        // queue usable again after reset
        set_enq(32'h0000_0400, 32'hB);
        step();
        clr_enq();
        chk("post_pc", 96'(dataD.instr.pc), 96'h400);
        chk("post_cnt", 96'(count), 96'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
